// File: rtl/btn_debounce_pulse.sv
// Conditions five raw buttons: 2-flop sync, debounce FSM, auto-repeat on directions, one-hot pulse arbitration.
// Latency: press pulse and held rise register DEBOUNCE_CYCLES+2 edges after the first edge sampling the new level.
// No backpressure: simultaneous pulses resolve C > U > D > L > R and losing pulses are dropped.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CW              = 32
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       BtnL_raw,
    input  logic       BtnR_raw,
    input  logic       BtnU_raw,
    input  logic       BtnD_raw,
    input  logic       BtnC_raw,
    output logic       BtnL,
    output logic       BtnR,
    output logic       BtnU,
    output logic       BtnD,
    output logic       BtnC,
    output logic [4:0] held
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    localparam logic [CW-1:0] DB  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RD  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP  = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [4:0] raw;
    logic [4:0] meta;
    logic [4:0] sync;
    logic [4:0] req;
    logic [4:0] grant;

    assign raw = {BtnC_raw, BtnD_raw, BtnU_raw, BtnR_raw, BtnL_raw};

    always_ff @(posedge Clk) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        localparam bit REPEATS = (i != 4);

        state_t        state_q;
        logic [CW-1:0] cnt_q;
        logic          rep_q;
        logic          held_q;
        logic [CW-1:0] thr;

        assign thr = rep_q ? RP : RD;

        // Repeats are gated by held_q so a button held through reset stays silent until re-pressed.
        assign req[i] = (state_q == PRESS_WAIT && sync[i] && cnt_q == DB) ||
                        (REPEATS && state_q == HELD && sync[i] && held_q && cnt_q == thr);
        assign held[i] = held_q;

        always_ff @(posedge Clk) begin
            if (reset) begin
                state_q <= REL_WAIT;
                cnt_q   <= '0;
                rep_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sync[i]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync[i]) begin
                            state_q <= IDLE;
                        end else if (cnt_q == DB) begin
                            state_q <= HELD;
                            held_q  <= 1'b1;
                            cnt_q   <= ONE;
                            rep_q   <= 1'b0;
                        end else if (cnt_q < DB) begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    HELD: begin
                        if (!sync[i]) begin
                            state_q <= REL_WAIT;
                            cnt_q   <= ONE;
                        end else if (REPEATS && held_q) begin
                            if (cnt_q == thr) begin
                                cnt_q <= ONE;
                                rep_q <= 1'b1;
                            end else if (cnt_q < thr) begin
                                cnt_q <= cnt_q + ONE;
                            end
                        end
                    end
                    REL_WAIT: begin
                        if (sync[i]) begin
                            state_q <= HELD;
                            cnt_q   <= ONE;
                            rep_q   <= 1'b0;
                        end else if (cnt_q == DB) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else if (cnt_q < DB) begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    default: begin
                        state_q <= REL_WAIT;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        grant = '0;
        if (req[4])      grant[4] = 1'b1;
        else if (req[2]) grant[2] = 1'b1;
        else if (req[3]) grant[3] = 1'b1;
        else if (req[0]) grant[0] = 1'b1;
        else if (req[1]) grant[1] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            {BtnC, BtnD, BtnU, BtnR, BtnL} <= '0;
        end else begin
            {BtnC, BtnD, BtnU, BtnR, BtnL} <= grant;
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed scenarios plus random button activity, compared each cycle against a run-length reference model.
module tb_btn_debounce_pulse;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       BtnL_raw = 1'b0, BtnR_raw = 1'b0, BtnU_raw = 1'b0, BtnD_raw = 1'b0, BtnC_raw = 1'b0;
    logic       BtnL, BtnR, BtnU, BtnD, BtnC;
    logic [4:0] held;

    always #5 Clk = ~Clk;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CW             (16)
    ) dut (
        .Clk     (Clk),
        .reset   (reset),
        .BtnL_raw(BtnL_raw),
        .BtnR_raw(BtnR_raw),
        .BtnU_raw(BtnU_raw),
        .BtnD_raw(BtnD_raw),
        .BtnC_raw(BtnC_raw),
        .BtnL    (BtnL),
        .BtnR    (BtnR),
        .BtnU    (BtnU),
        .BtnD    (BtnD),
        .BtnC    (BtnC),
        .held    (held)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pcnt[5];
    int rtimes[$];

    // Reference model: sync delay line, run length of the synced level, accepted level, repeat timer.
    logic [4:0] q1, q2, last, acc, armed, exp_pulse;
    int run[5], since[5], target[5];

    task automatic model_edge(input logic [4:0] r, input logic rst);
        logic [4:0] rq;
        logic s, prev;
        int pri[5];
        bit done;
        pri = '{4, 2, 3, 0, 1};
        rq = '0;
        if (rst) begin
            q1 = '0; q2 = '0; last = '0; acc = '1; armed = '0; exp_pulse = '0;
            for (int i = 0; i < 5; i++) begin
                run[i] = 0; since[i] = 0; target[i] = RD;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                s = q2[i];
                prev = last[i];
                run[i] = (s == prev) ? run[i] + 1 : 1;
                last[i] = s;
                if (s != acc[i] && run[i] == D + 1) begin
                    acc[i] = s;
                    armed[i] = s;
                    if (s) begin
                        rq[i] = 1'b1;
                        since[i] = 0;
                        target[i] = RD;
                    end
                end else if (acc[i] && s) begin
                    if (!prev) begin
                        since[i] = 0;
                        target[i] = RD;
                    end else if (armed[i] && i != 4) begin
                        since[i]++;
                        if (since[i] == target[i]) begin
                            rq[i] = 1'b1;
                            since[i] = 0;
                            target[i] = RP;
                        end
                    end
                end
            end
            q2 = q1;
            q1 = r;
            exp_pulse = '0;
            done = 0;
            for (int j = 0; j < 5; j++) begin
                if (!done && rq[pri[j]]) begin
                    exp_pulse[pri[j]] = 1'b1;
                    done = 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [4:0] pulses;
        @(posedge Clk);
        model_edge({BtnC_raw, BtnD_raw, BtnU_raw, BtnR_raw, BtnL_raw}, reset);
        cyc++;
        #1;
        pulses = {BtnC, BtnD, BtnU, BtnR, BtnL};
        check("pulses", 32'(pulses), 32'(exp_pulse));
        check("held", 32'(held), 32'(armed));
        check("onehot", 32'($countones(pulses) <= 1), 32'd1);
        for (int i = 0; i < 5; i++) if (pulses[i]) pcnt[i]++;
        if (pulses[1]) rtimes.push_back(cyc);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int base_l, base_u, base_c, base_d, t_first;
        int dur[5];
        logic [4:0] lvl;
        for (int i = 0; i < 5; i++) pcnt[i] = 0;

        // 1: reset, idle, then centre press latency
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(5);
        check("t1_idle", {22'd0, BtnC, BtnD, BtnU, BtnR, BtnL, held}, 32'd0);
        BtnC_raw = 1'b1;
        steps(6);
        check("t1_c_early", 32'(BtnC), 32'd0);
        step();
        check("t1_c_pulse", 32'(BtnC), 32'd1);
        check("t1_c_held", 32'(held[4]), 32'd1);
        step();
        check("t1_c_width", 32'(BtnC), 32'd0);
        BtnC_raw = 1'b0;
        steps(10);

        // 2: bounce on left is rejected
        base_l = pcnt[0];
        for (int k = 0; k < 4; k++) begin
            BtnL_raw = ~BtnL_raw;
            step();
        end
        BtnL_raw = 1'b0;
        steps(10);
        check("t2_l_none", 32'(pcnt[0] - base_l), 32'd0);
        check("t2_l_held", 32'(held[0]), 32'd0);

        // 3: right held, auto-repeat cadence, release latency
        rtimes.delete();
        BtnR_raw = 1'b1;
        steps(7);
        t_first = cyc;
        steps(40);
        BtnR_raw = 1'b0;
        steps(6);
        check("t3_r_held_still", 32'(held[1]), 32'd1);
        step();
        check("t3_r_released", 32'(held[1]), 32'd0);
        check("t3_r_count", 32'(rtimes.size()), 32'd4);
        if (rtimes.size() >= 4) begin
            check("t3_r_first", 32'(rtimes[0]), 32'(t_first));
            check("t3_r_delay", 32'(rtimes[1] - rtimes[0]), 32'(RD));
            check("t3_r_per1", 32'(rtimes[2] - rtimes[1]), 32'(RP));
            check("t3_r_per2", 32'(rtimes[3] - rtimes[2]), 32'(RP));
        end
        steps(4);

        // 4: centre never repeats
        base_c = pcnt[4];
        BtnC_raw = 1'b1;
        steps(60);
        BtnC_raw = 1'b0;
        steps(8);
        check("t4_c_once", 32'(pcnt[4] - base_c), 32'd1);

        // 5: simultaneous up and left, up wins
        base_u = pcnt[2];
        base_l = pcnt[0];
        BtnU_raw = 1'b1;
        BtnL_raw = 1'b1;
        steps(10);
        BtnU_raw = 1'b0;
        BtnL_raw = 1'b0;
        steps(8);
        check("t5_u_once", 32'(pcnt[2] - base_u), 32'd1);
        check("t5_l_dropped", 32'(pcnt[0] - base_l), 32'd0);

        // 6: down held through reset stays silent until released and pressed again
        base_d = pcnt[3];
        BtnD_raw = 1'b1;
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(10);
        check("t6_d_silent", 32'(pcnt[3] - base_d), 32'd0);
        BtnD_raw = 1'b0;
        steps(5);
        BtnD_raw = 1'b1;
        steps(6);
        check("t6_d_early", 32'(pcnt[3] - base_d), 32'd0);
        step();
        check("t6_d_pulse", 32'(BtnD), 32'd1);
        BtnD_raw = 1'b0;
        steps(8);

        // random activity with occasional reset
        lvl = '0;
        for (int i = 0; i < 5; i++) dur[i] = $urandom_range(1, 30);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 5; i++) begin
                if (dur[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
                end
                dur[i]--;
            end
            {BtnC_raw, BtnD_raw, BtnU_raw, BtnR_raw, BtnL_raw} = lvl;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
